// File: rtl/cesa_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-estimating segmented adder:
// default geometry, the mode encoding, the inter-segment carry estimate,
// the stage-count derivation and the parameter legality check.
package cesa_pipe_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 16;
  // The estimate looks at the top four bit pairs of the lower segment.
  localparam int EST_BITS  = 4;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // One pipeline stage per segment.
  function automatic int nblk_of(input int width, input int block);
    return width / block;
  endfunction

  // Geometry must split into whole segments wide enough for the estimate.
  function automatic bit params_ok(input int width, input int block);
    return (block >= EST_BITS) && (width > 0) && ((width % block) == 0);
  endfunction

  // Carry estimate out of a segment from its top four bit pairs.
  // Bit 3 is the segment MSB (t), bit 0 is t-3.
  // When bits t and t-1 both propagate, the carry is guessed from bits
  // t-2/t-3; otherwise it is resolved from bits t/t-1 alone.
  function automatic logic est_carry(input logic [EST_BITS-1:0] a_top,
                                     input logic [EST_BITS-1:0] b_top);
    logic x, y, z, w, p, q, r, s;
    logic sel, pre, post;
    x    = a_top[3];
    y    = b_top[3];
    z    = a_top[2];
    w    = b_top[2];
    p    = a_top[1];
    q    = b_top[1];
    r    = a_top[0];
    s    = b_top[0];
    sel  = (x ^ y) & (z ^ w);
    pre  = (p & q) | (q & r & s) | (p & r & s);
    post = (x & y) | (y & z & w) | (x & z & w);
    return sel ? pre : post;
  endfunction

endpackage

// File: rtl/cesa_pipe_adder_if.sv
// Operand/result handshake bundle of the segmented adder. The adder sits on
// the slave side; the producer/consumer pair drives the master side.
interface cesa_pipe_adder_if #(
  parameter int WIDTH = cesa_pipe_adder_pkg::DEF_WIDTH
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             approx_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             err_o;

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, approx_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, cout_o, err_o
  );

  modport master (
    output in_valid_i, a_i, b_i, cin_i, approx_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, cout_o, err_o
  );

endinterface

// File: rtl/cesa_pipe_adder_stage.sv
// One pipeline stage: resolves segment IDX of the sum, tracks the true
// ripple carry alongside the carry actually used, accumulates the
// estimation-error flag and registers everything under the global stall.
module cesa_stage
  import cesa_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             approx_in,
  input  logic             err_in,
  input  logic             carry_in,      // true carry into this segment
  output logic             valid_reg,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic [WIDTH-1:0] sum_reg,
  output logic             approx_reg,
  output logic             err_reg,
  output logic             carry_true_reg,
  output logic             carry_used_reg
);

  logic [BLOCK-1:0] a_seg;
  logic [BLOCK-1:0] b_seg;
  logic             cin_used;
  logic [BLOCK:0]   seg_true;
  logic [BLOCK:0]   seg_used;
  logic [WIDTH-1:0] sum_next;
  logic             err_next;

  assign a_seg = a_in[IDX*BLOCK +: BLOCK];
  assign b_seg = b_in[IDX*BLOCK +: BLOCK];

  // Segment 0 always takes the external carry; higher segments pick the
  // estimate of the segment below or the true carry, per transaction.
  generate
    if (IDX == 0) begin : g_first
      assign cin_used = carry_in;
    end else begin : g_est
      logic est_bit;
      assign est_bit  = est_carry(a_in[IDX*BLOCK-1 -: EST_BITS],
                                  b_in[IDX*BLOCK-1 -: EST_BITS]);
      assign cin_used = (mode_e'(approx_in) == MODE_APPROX) ? est_bit : carry_in;
    end
  endgenerate

  // Both adds run every cycle: the true one feeds the exact chain and the
  // error check, the used one produces the sum bits and the approx carry-out.
  assign seg_true = {1'b0, a_seg} + {1'b0, b_seg} + {{BLOCK{1'b0}}, carry_in};
  assign seg_used = {1'b0, a_seg} + {1'b0, b_seg} + {{BLOCK{1'b0}}, cin_used};
  assign err_next = err_in | (approx_in & (cin_used ^ carry_in));

  // Splice this segment's result into the partial sum travelling with the data.
  always_comb begin
    sum_next                      = sum_in;
    sum_next[IDX*BLOCK +: BLOCK]  = seg_used[BLOCK-1:0];
  end

  // Stage register: cleared by reset, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      sum_reg        <= '0;
      approx_reg     <= 1'b0;
      err_reg        <= 1'b0;
      carry_true_reg <= 1'b0;
      carry_used_reg <= 1'b0;
    end else if (advance) begin
      valid_reg      <= valid_in;
      a_reg          <= a_in;
      b_reg          <= b_in;
      sum_reg        <= sum_next;
      approx_reg     <= approx_in;
      err_reg        <= err_next;
      carry_true_reg <= seg_true[BLOCK];
      carry_used_reg <= seg_used[BLOCK];
    end
  end

endmodule

// File: rtl/cesa_pipe_adder.sv
// Pipelined carry-estimating segmented adder: NBLK segment stages chained
// under one global stall, with valid/ready handshakes on input and output.
module cesa_pipe_adder
  import cesa_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cesa_pipe_adder_if.slave      bus
);

  localparam int NBLK = nblk_of(WIDTH, BLOCK);

  generate
    if (!params_ok(WIDTH, BLOCK)) begin : g_bad_params
      $error("cesa_pipe_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 4");
    end
  endgenerate

  logic [NBLK-1:0]  valid_q;
  logic [NBLK-1:0]  approx_q;
  logic [NBLK-1:0]  err_q;
  logic [NBLK-1:0]  ctrue_q;
  logic [NBLK-1:0]  cused_q;
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic [WIDTH-1:0] sum_q [NBLK];
  logic             advance;

  // Whole pipeline moves unless a finished result is waiting on the consumer.
  assign advance        = !valid_q[NBLK-1] || bus.out_ready_i;
  assign bus.in_ready_o = advance;

  assign bus.out_valid_o = valid_q[NBLK-1];
  assign bus.sum_o       = sum_q[NBLK-1];
  assign bus.cout_o      = cused_q[NBLK-1];
  assign bus.err_o       = err_q[NBLK-1];

  // The last stage's operands and mode and the per-stage used carries below
  // the top segment have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[NBLK-1], b_q[NBLK-1], approx_q, ctrue_q[NBLK-1], cused_q};

  genvar gi;
  generate
    for (gi = 0; gi < NBLK; gi++) begin : g_stage
      logic             v_in;
      logic             appr_in;
      logic             err_in;
      logic             c_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;

      if (gi == 0) begin : g_src
        assign v_in    = bus.in_valid_i;
        assign a_in    = bus.a_i;
        assign b_in    = bus.b_i;
        assign s_in    = '0;
        assign appr_in = bus.approx_i;
        assign err_in  = 1'b0;
        assign c_in    = bus.cin_i;
      end else begin : g_chain
        assign v_in    = valid_q[gi-1];
        assign a_in    = a_q[gi-1];
        assign b_in    = b_q[gi-1];
        assign s_in    = sum_q[gi-1];
        assign appr_in = approx_q[gi-1];
        assign err_in  = err_q[gi-1];
        assign c_in    = ctrue_q[gi-1];
      end

      cesa_stage #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK),
        .IDX   (gi)
      ) u_stage (
        .clk            (clk_i),
        .rst_n          (rst_ni),
        .advance        (advance),
        .valid_in       (v_in),
        .a_in           (a_in),
        .b_in           (b_in),
        .sum_in         (s_in),
        .approx_in      (appr_in),
        .err_in         (err_in),
        .carry_in       (c_in),
        .valid_reg      (valid_q[gi]),
        .a_reg          (a_q[gi]),
        .b_reg          (b_q[gi]),
        .sum_reg        (sum_q[gi]),
        .approx_reg     (approx_q[gi]),
        .err_reg        (err_q[gi]),
        .carry_true_reg (ctrue_q[gi]),
        .carry_used_reg (cused_q[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_cesa_pipe_adder.sv
// Scoreboard bench for cesa_pipe_adder (WIDTH=32, BLOCK=16): directed
// vectors with hand-computed results, a decoupled output monitor, plus
// back-pressure and mid-flight reset scenarios.
module tb_cesa_pipe_adder;
  import cesa_pipe_adder_pkg::*;

  localparam int WIDTH = 32;
  localparam int BLOCK = 16;
  localparam int NBLK  = 2;
  localparam int NVEC  = 11;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        approx;
    logic [31:0] sum;
    logic        cout;
    logic        err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        cout;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cesa_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  cesa_pipe_adder #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   pop_cyc_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pop_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial begin
    //          a             b             cin   apx   sum           cout  err
    vecs[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000C000, 32'h00004000, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    vecs[5]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 32'hACF13568, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFFF8000, 32'h00008000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1};
    vecs[8]  = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vecs[9]  = '{32'hFFFF0000, 32'hFFFF0000, 1'b0, 1'b1, 32'hFFFE0000, 1'b1, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'hFFFF0000, 1'b0, 1'b1};
  end

  // Monitor: pop and compare whenever a result handshake is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum=%h with no pending transaction, required none", bus.sum_o);
        end else begin
          e = exp_q.pop_front();
          $display("result id=%0d sum=%h cout=%b err=%b cyc=%0d", e.id, bus.sum_o, bus.cout_o, bus.err_o, cyc);
          check($sformatf("sum[%0d]", e.id), 64'(bus.sum_o), 64'(e.sum));
          check($sformatf("cout[%0d]", e.id), 64'(bus.cout_o), 64'(e.cout));
          check($sformatf("err[%0d]", e.id), 64'(bus.err_o), 64'(e.err));
          if (e.chk_lat)
            check($sformatf("latency[%0d]", e.id), 64'(cyc - e.acc_cyc), 64'(NBLK));
          pop_cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic set_vec(input int idx);
    bus.a_i      = vecs[idx].a;
    bus.b_i      = vecs[idx].b;
    bus.cin_i    = vecs[idx].cin;
    bus.approx_i = vecs[idx].approx;
  endtask

  task automatic push_exp(input int idx, input bit lat);
    exp_t e;
    e.id      = idx;
    e.sum     = vecs[idx].sum;
    e.cout    = vecs[idx].cout;
    e.err     = vecs[idx].err;
    e.acc_cyc = cyc;
    e.chk_lat = lat;
    exp_q.push_back(e);
    $display("issue id=%0d a=%h b=%h cin=%b approx=%b cyc=%0d", idx, vecs[idx].a, vecs[idx].b,
             vecs[idx].cin, vecs[idx].approx, cyc);
  endtask

  // Starts and ends at a falling edge; waits (bounded) for in_ready_o.
  task automatic send(input int idx, input bit lat);
    int n;
    n = 0;
    set_vec(idx);
    bus.in_valid_i = 1'b1;
    #1;
    while (!bus.in_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready_o) begin
      check($sformatf("send_timeout[%0d]", idx), 64'(bus.in_ready_o), 64'd1);
    end else begin
      push_exp(idx, lat);
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc;
    int pc_before;
    int q;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.cin_i       = 1'b0;
    bus.approx_i    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_sum", 64'(bus.sum_o), 64'd0);
    check("rst_cout", 64'(bus.cout_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors back to back, full throughput, latency checked.
    for (int i = 0; i < NVEC; i++) send(i, 1'b1);
    drain();

    // Back-pressure: three offers with the consumer stalled.
    bus.out_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      set_vec((i == 0) ? 4 : (i == 1) ? 2 : 8);
      bus.in_valid_i = 1'b1;
      #1;
      if (bus.in_ready_o) begin
        push_exp((i == 0) ? 4 : (i == 1) ? 2 : 8, 1'b0);
        acc++;
      end
      @(negedge clk);
    end
    check("bp_accepted", 64'(acc), 64'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid_o), 64'd1);
      check("bp_sum_stable", 64'(bus.sum_o), 64'(vecs[4].sum));
      @(negedge clk);
    end
    // Release: the held third offer is taken in the same cycle.
    bus.out_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready_o), 64'd1);
    if (bus.in_ready_o) push_exp(8, 1'b0);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    drain();
    q = pop_cyc_q.size();
    if (q >= 3) begin
      check("bp_consecutive_1", 64'(pop_cyc_q[q-2] - pop_cyc_q[q-3]), 64'd1);
      check("bp_consecutive_2", 64'(pop_cyc_q[q-1] - pop_cyc_q[q-2]), 64'd1);
    end else begin
      check("bp_result_count", 64'(q), 64'd3);
    end

    // Reset with two transactions in flight.
    bus.out_ready_i = 1'b0;
    send(4, 1'b0);
    send(6, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("midrst_sum", 64'(bus.sum_o), 64'd0);
    check("midrst_cout", 64'(bus.cout_o), 64'd0);
    check("midrst_err", 64'(bus.err_o), 64'd0);
    exp_q.delete();
    pc_before = pop_cnt;
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_stale", 64'(pop_cnt - pc_before), 64'd0);

    // Normal operation resumes after reset.
    send(3, 1'b1);
    send(10, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
